// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: response-queue entry layout, ack constant and parameter legality check
package data_sram_responder_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] DSRAM_ACK_RDATA = 32'h0;
  typedef struct packed {
    logic              is_wr;
    logic [DATA_W-1:0] data;
  } ent_t;
  function automatic int cnt_w(input int lat);
    return lat > 1 ? $clog2(lat) : 1;
  endfunction
  function automatic bit params_ok(input int depth, input int lat, input int outst);
    return lat >= 1 && outst >= 1 && depth >= 2 && (depth & (depth - 1)) == 0;
  endfunction
endpackage

// File: rtl/data_sram_responder_queue.sv
// dsram_resp_queue: in-order circular response FIFO; every entry counts down to its fixed-latency response slot
module dsram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  ent_t ent_i,
  output logic head_ready,
  output ent_t head_o,
  output logic full_o,
  input  logic pop
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int NW = $clog2(OUTSTANDING + 1);
  localparam int CW = cnt_w(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  ent_t          ent_q [OUTSTANDING];
  logic [CW-1:0] cnt_q [OUTSTANDING];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [NW-1:0] count_q, count_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  assign head_ready = (count_q != '0) && (cnt_q[head_q] == '0);
  assign head_o     = ent_q[head_q];
  assign full_o     = count_q == NW'(OUTSTANDING);
  always_comb begin
    head_d  = pop ? inc(head_q) : head_q;
    tail_d  = push ? inc(tail_q) : tail_q;
    count_d = count_q + NW'(push) - NW'(pop);
  end
  always_ff @(posedge clk) if (push) ent_q[tail_q] <= ent_i;
  // a push into the slot being retired in the same cycle overrides the countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
      if (push) cnt_q[tail_q] <= CNT_INIT;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: byte-enabled data RAM answering SRAM-like requests in order after a fixed latency
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (!params_ok(DEPTH_WORDS, LATENCY, OUTSTANDING)) begin : g_param_err
    $error("data_sram_responder: illegal parameters");
  end
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          acc, full, head_ready, unused_addr;
  ent_t          head, push_ent;
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign data_ok     = head_ready;
  assign addr_ok     = !full || head_ready;
  assign acc         = req && addr_ok;
  assign rdata       = (head_ready && !head.is_wr) ? head.data : DSRAM_ACK_RDATA;
  assign push_ent    = '{is_wr: wr, data: wr ? DSRAM_ACK_RDATA : mem_q[idx]};
  // array is deliberately unreset so contents survive a reset pulse
  always_ff @(posedge clk)
    if (acc && wr)
      for (int i = 0; i < 4; i++) if (wstrb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
  dsram_resp_queue #(
    .LATENCY    (LATENCY),
    .OUTSTANDING(OUTSTANDING)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (acc),
    .ent_i     (push_ent),
    .head_ready(head_ready),
    .head_o    (head),
    .full_o    (full),
    .pop       (head_ready)
  );
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: two configurations (L2/O2 and L3/O1) checked every cycle against a timed response model
module tb_data_sram_responder;
  typedef struct {
    int          due;
    bit          is_wr;
    logic [31:0] data;
  } rsp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic        req [2];
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        aok [2], dok [2];
  logic [31:0] rd [2];
  int          lat [2] = '{2, 3};
  int          outst [2] = '{2, 1};
  logic [31:0] mem_m [2][1024];
  rsp_t        q [2][$];
  logic [31:0] obs [2];
  int          cyc = 0, total = 0, bad = 0, acc_cyc = 0;
  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .OUTSTANDING(2)) u_a (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]));
  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .OUTSTANDING(1)) u_b (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, o, e, cyc);
    end
  endtask
  // drive one cycle on instance s; both instances are checked against the model
  task automatic step(input int s, input bit r, input bit w, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] d, output bit accd);
    req[0] = 1'b0; req[1] = 1'b0; req[s] = r;
    wr = w; wstrb = be; addr = a; wdata = d;
    #1;
    accd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bit ed, ea;
      logic [31:0] er;
      int wi;
      ed = q[k].size() > 0 && q[k][0].due == cyc;
      er = (ed && !q[k][0].is_wr) ? q[k][0].data : 32'h0;
      ea = q[k].size() < outst[k] || ed;
      chk($sformatf("data_ok%0d", k), {31'b0, dok[k]}, {31'b0, ed});
      chk($sformatf("rdata%0d", k), rd[k], er);
      chk($sformatf("addr_ok%0d", k), {31'b0, aok[k]}, {31'b0, ea});
      if (ed) begin
        obs[k] = rd[k];
        void'(q[k].pop_front());
      end
      if (k == s && r && ea) begin
        accd = 1'b1;
        acc_cyc = cyc;
        wi = int'((a >> 2) % 1024);
        q[k].push_back('{cyc + lat[k], w, w ? 32'h0 : mem_m[k][wi]});
        if (w) for (int b = 0; b < 4; b++) if (be[b]) mem_m[k][wi][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic xfer(input int s, input bit w, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    bit accd = 1'b0;
    for (int t = 0; t < 8 && !accd; t++) step(s, 1'b1, w, be, a, d, accd);
    if (!accd) chk("accept_timeout", 32'h0, 32'h1);
  endtask
  task automatic idle(input int n);
    bit accd;
    for (int t = 0; t < n; t++) step(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, accd);
  endtask
  task automatic do_reset();
    reset = 1'b1; req[0] = 1'b0; req[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_addr_ok%0d", k), {31'b0, aok[k]}, 32'h1);
      chk($sformatf("rst_data_ok%0d", k), {31'b0, dok[k]}, 32'h0);
      chk($sformatf("rst_rdata%0d", k), rd[k], 32'h0);
      q[k].delete();
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    int a0, a1, a2, a3;
    reset = 1'b1; req[0] = 1'b0; req[1] = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = '0; wdata = '0;
    @(negedge clk);
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) xfer(s, 1'b1, 4'hF, 32'(i * 4), $urandom);
      xfer(s, 1'b1, 4'hF, 32'h40, 32'hAABBCCDD);
      xfer(s, 1'b1, 4'hF, 32'h80, $urandom);
    end
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    idle(4);
    do_reset();
    obs[0] = '0;
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0);
    idle(4);
    chk("preload_read", obs[0], 32'hDEADBEEF);
    xfer(0, 1'b1, 4'b0101, 32'h40, 32'h11223344);
    idle(3);
    xfer(0, 1'b0, 4'h0, 32'h40, 32'h0);
    idle(3);
    chk("strobe_merge", obs[0], 32'hAA22CC44);
    xfer(0, 1'b1, 4'hF, 32'h80, 32'hCAFEF00D);
    xfer(0, 1'b0, 4'h0, 32'h80, 32'h0);
    idle(3);
    chk("b2b_read", obs[0], 32'hCAFEF00D);
    xfer(1, 1'b0, 4'h0, 32'h0, 32'h0); a0 = acc_cyc;
    xfer(1, 1'b0, 4'h0, 32'h4, 32'h0); a1 = acc_cyc;
    xfer(1, 1'b0, 4'h0, 32'h8, 32'h0); a2 = acc_cyc;
    chk("o1_spacing1", 32'(a1 - a0), 32'd3);
    chk("o1_spacing2", 32'(a2 - a1), 32'd3);
    idle(4);
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0);
    do_reset();
    idle(3);
    obs[0] = '0;
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0);
    idle(3);
    chk("mem_after_reset", obs[0], 32'hDEADBEEF);
    xfer(0, 1'b1, 4'hF, 32'h1010, 32'h5A5A1234);
    xfer(0, 1'b0, 4'h0, 32'h0010, 32'h0);
    idle(3);
    chk("alias", obs[0], 32'h5A5A1234);
    for (int n = 0; n < 400; n++) begin
      bit accd;
      int s;
      s = int'($urandom_range(0, 1));
      a3 = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        xfer(s, 1'($urandom), 4'($urandom), {$urandom_range(0, 32'hFFFFF) > 0 ? 20'($urandom) : 20'h0, 6'b0, 4'(a3), 2'($urandom)}, $urandom);
      else
        step(s, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, accd);
    end
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
